// File: rtl/cache_arbiter_if.sv
// cache_arbiter_if
//   Bundles the instruction-cache port, the data-cache port and the
//   cacheline-adapter (dfp) port of the cache arbiter.
//   Modports:
//     slave  - the arbiter: takes cache requests and adapter responses,
//              drives cache responses and adapter requests.
//     master - the environment: the two caches plus the adapter.
//   Signals:
//     i_addr/i_read -> i_rdata/i_resp              instruction-cache line reads
//     d_addr/d_read/d_write/d_wdata -> d_rdata/d_resp  data-cache reads/writebacks
//     dfp_addr/dfp_read/dfp_write/dfp_wdata -> dfp_rdata/dfp_resp  adapter side
interface cache_arbiter_if;
    logic [31:0]  i_addr;
    logic         i_read;
    logic [255:0] i_rdata;
    logic         i_resp;

    logic [31:0]  d_addr;
    logic         d_read;
    logic         d_write;
    logic [255:0] d_wdata;
    logic [255:0] d_rdata;
    logic         d_resp;

    logic [31:0]  dfp_addr;
    logic         dfp_read;
    logic         dfp_write;
    logic [255:0] dfp_wdata;
    logic [255:0] dfp_rdata;
    logic         dfp_resp;

    modport slave (
        input  i_addr, i_read, d_addr, d_read, d_write, d_wdata, dfp_rdata, dfp_resp,
        output i_rdata, i_resp, d_rdata, d_resp, dfp_addr, dfp_read, dfp_write, dfp_wdata
    );

    modport master (
        output i_addr, i_read, d_addr, d_read, d_write, d_wdata, dfp_rdata, dfp_resp,
        input  i_rdata, i_resp, d_rdata, d_resp, dfp_addr, dfp_read, dfp_write, dfp_wdata
    );
endinterface

// File: rtl/cache_arbiter.sv
// cache_arbiter
//   Shares one cacheline adapter between an instruction cache and a data
//   cache. One line transaction is in flight at a time; a tie in IDLE goes to
//   the cache that was not granted last. The granted request is captured at
//   grant time and replayed to the adapter until it responds; the response is
//   forwarded to the owner in the same cycle. A one-cycle RECOVER state after
//   every response keeps a requester that is slow to drop its request from
//   being granted twice.
//   Ports:
//     clk  - clock, rising edge
//     rst  - asynchronous active-high reset
//     bus  - cache_arbiter_if.slave (both cache ports and the adapter port)
module cache_arbiter (
    input  logic           clk,
    input  logic           rst,
    cache_arbiter_if.slave bus
);

    typedef enum logic [1:0] {IDLE, I_BUSY, D_BUSY, RECOVER} state_t;

    localparam logic GRANT_I = 1'b0;
    localparam logic GRANT_D = 1'b1;

    state_t       state_q, state_d;
    logic         last_grant_q, last_grant_d;
    logic [31:0]  addr_q, addr_d;
    logic         write_q, write_d;
    logic [255:0] wdata_q, wdata_d;

    logic i_req;
    logic d_req;
    logic busy;

    // Line addresses are 32-byte aligned, so the low five request address
    // bits never reach the adapter.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{bus.i_addr[4:0], bus.d_addr[4:0]};

    assign i_req = bus.i_read;
    assign d_req = bus.d_read | bus.d_write;
    assign busy  = (state_q == I_BUSY) || (state_q == D_BUSY);

    always_comb begin
        // NOTE: every variable gets its hold value first, so no branch can
        // leave one unassigned and infer a latch.
        state_d      = state_q;
        last_grant_d = last_grant_q;
        addr_d       = addr_q;
        write_d      = write_q;
        wdata_d      = wdata_q;

        case (state_q)
            IDLE: begin
                // I wins when it is alone or when D was granted last.
                if (i_req && (!d_req || last_grant_q == GRANT_D)) begin
                    state_d      = I_BUSY;
                    last_grant_d = GRANT_I;
                    addr_d       = {bus.i_addr[31:5], 5'b0};
                    write_d      = 1'b0;
                    wdata_d      = '0;
                end else if (d_req) begin
                    state_d      = D_BUSY;
                    last_grant_d = GRANT_D;
                    addr_d       = {bus.d_addr[31:5], 5'b0};
                    // A writeback beats a read when both are raised.
                    write_d      = bus.d_write;
                    wdata_d      = bus.d_write ? bus.d_wdata : '0;
                end
            end
            I_BUSY, D_BUSY: begin
                if (bus.dfp_resp) begin
                    state_d = RECOVER;
                end
            end
            RECOVER: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            last_grant_q <= GRANT_D;
            addr_q       <= '0;
            write_q      <= 1'b0;
            wdata_q      <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values, independent of statement order.
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            addr_q       <= addr_d;
            write_q      <= write_d;
            wdata_q      <= wdata_d;
        end
    end

    // Adapter side is driven purely from the captured request, gated by the
    // busy states so it reads as zero everywhere else (including in reset).
    assign bus.dfp_addr  = busy ? addr_q : '0;
    assign bus.dfp_read  = busy & ~write_q;
    assign bus.dfp_write = busy & write_q;
    assign bus.dfp_wdata = busy ? wdata_q : '0;

    assign bus.i_rdata = bus.dfp_rdata;
    assign bus.d_rdata = bus.dfp_rdata;

    // Zero-cycle response forwarding to whichever cache owns the transaction.
    assign bus.i_resp = (state_q == I_BUSY) & bus.dfp_resp;
    assign bus.d_resp = (state_q == D_BUSY) & bus.dfp_resp;

endmodule

// File: tb/tb_cache_arbiter.sv
// tb_cache_arbiter
//   Two cache drivers issue line requests and push the expected adapter
//   transaction into per-cache queues; an adapter model answers with random
//   latency; a monitor on the falling edge decides which queued request the
//   arbiter ought to have granted (round robin over the requests visible in
//   the grant cycle) and compares the adapter-side and cache-side outputs.
module tb_cache_arbiter;

    typedef struct {
        logic [31:0]  addr;
        bit           write;
        logic [255:0] wdata;
        int           cyc;
    } txn_t;

    localparam int TMO = 200;

    logic clk;
    logic rst;
    cache_arbiter_if bus ();

    cache_arbiter dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks   = 0;
    int failures = 0;

    txn_t iq[$];
    txn_t dq[$];
    logic [31:0] grant_log[$];

    bit mon_en    = 1'b0;
    bit ad_en     = 1'b0;
    bit spur      = 1'b0;
    int fixed_lat = 0;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [255:0] rand256();
        logic [255:0] r;
        for (int k = 0; k < 8; k++) r[k*32 +: 32] = $urandom;
        return r;
    endfunction

    // ---------------- adapter model ----------------
    bit in_req    = 1'b0;
    int wait_left = 0;
    bit gen;
    initial begin
        bus.dfp_resp  = 1'b0;
        bus.dfp_rdata = '0;
        forever begin
            @(posedge clk);
            #2;
            gen = 1'b0;
            if (!ad_en) begin
                in_req = 1'b0;
            end else if (bus.dfp_read || bus.dfp_write) begin
                if (!in_req) begin
                    in_req    = 1'b1;
                    wait_left = (fixed_lat >= 0) ? fixed_lat : int'($urandom_range(0, 6));
                end
                if (wait_left == 0) begin
                    gen    = 1'b1;
                    in_req = 1'b0;
                end else begin
                    wait_left--;
                end
            end
            bus.dfp_resp  = gen | spur;
            bus.dfp_rdata = rand256();
        end
    end

    // ---------------- monitor / scoreboard ----------------
    bit   busy_m   = 1'b0;
    bit   last_m   = 1'b1;   // 1 = data cache
    bit   cur_d    = 1'b0;
    int   idle_cnt = 2;
    txn_t cur_t;
    bit   act, i_c, d_c;

    always @(negedge clk) begin
        if (mon_en) begin
            act = bus.dfp_read || bus.dfp_write;
            check("dfp_rw_exclusive", bus.dfp_read && bus.dfp_write, 1'b0);
            check("i_rdata_pass", bus.i_rdata, bus.dfp_rdata);
            check("d_rdata_pass", bus.d_rdata, bus.dfp_rdata);
            if (!act) begin
                check("idle_dfp_addr", bus.dfp_addr, 32'h0);
                check("idle_dfp_wdata", bus.dfp_wdata, 256'h0);
            end
            if (act && !busy_m) begin
                grant_log.push_back(bus.dfp_addr);
                check("recover_gap", idle_cnt >= 2, 1'b1);
                i_c = iq.size() > 0 && iq[0].cyc < cyc;
                d_c = dq.size() > 0 && dq[0].cyc < cyc;
                if (!i_c && !d_c) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_grant: got dfp_addr %h with no pending request", bus.dfp_addr);
                end else begin
                    cur_d  = d_c && (!i_c || !last_m);
                    last_m = cur_d;
                    cur_t  = cur_d ? dq[0] : iq[0];
                    busy_m = 1'b1;
                end
            end
            if (busy_m && act) begin
                check("dfp_addr", bus.dfp_addr, cur_t.addr);
                check("dfp_write", bus.dfp_write, cur_t.write);
                check("dfp_read", bus.dfp_read, !cur_t.write);
                if (cur_t.write) check("dfp_wdata", bus.dfp_wdata, cur_t.wdata);
            end
            if (busy_m && !act) begin
                check("dfp_request_dropped", act, 1'b1);
            end
            check("i_resp", bus.i_resp, busy_m && act && !cur_d && bus.dfp_resp);
            check("d_resp", bus.d_resp, busy_m && act && cur_d && bus.dfp_resp);
            if (busy_m && bus.dfp_resp) begin
                if (cur_d) void'(dq.pop_front());
                else       void'(iq.pop_front());
                busy_m = 1'b0;
            end
            idle_cnt = act ? 0 : idle_cnt + 1;
        end
    end

    // ---------------- cache drivers ----------------
    task automatic i_txn(input logic [31:0] addr, input bit hold, output int n);
        txn_t t;
        @(posedge clk);
        #1;
        bus.i_addr = addr;
        bus.i_read = 1'b1;
        t.addr  = {addr[31:5], 5'b0};
        t.write = 1'b0;
        t.wdata = '0;
        t.cyc   = cyc;
        iq.push_back(t);
        n = 0;
        while (n < TMO) begin
            @(negedge clk);
            n++;
            if (bus.i_resp) break;
        end
        check("i_resp_arrived", bus.i_resp, 1'b1);
        @(posedge clk);
        #1;
        if (hold) begin
            @(posedge clk);
            #1;
        end
        bus.i_read = 1'b0;
    endtask

    task automatic d_txn(input logic [31:0] addr, input bit rd, input bit wr,
                         input logic [255:0] wdata, input bit hold, input bit wiggle,
                         output int n);
        txn_t t;
        @(posedge clk);
        #1;
        bus.d_addr  = addr;
        bus.d_read  = rd;
        bus.d_write = wr;
        bus.d_wdata = wdata;
        t.addr  = {addr[31:5], 5'b0};
        t.write = wr;
        t.wdata = wr ? wdata : '0;
        t.cyc   = cyc;
        dq.push_back(t);
        n = 0;
        while (n < TMO) begin
            @(negedge clk);
            n++;
            if (wiggle && n >= 2) begin
                bus.d_addr  = $urandom;
                bus.d_wdata = rand256();
            end
            if (bus.d_resp) break;
        end
        check("d_resp_arrived", bus.d_resp, 1'b1);
        @(posedge clk);
        #1;
        if (hold) begin
            @(posedge clk);
            #1;
        end
        bus.d_read  = 1'b0;
        bus.d_write = 1'b0;
    endtask

    // ---------------- main sequence ----------------
    int   n_i, n_d, n_x, op;
    txn_t td;
    logic [255:0] pat_b;

    initial begin
        rst         = 1'b1;
        bus.i_addr  = '0;
        bus.i_read  = 1'b0;
        bus.d_addr  = '0;
        bus.d_read  = 1'b0;
        bus.d_write = 1'b0;
        bus.d_wdata = '0;

        // Reset state.
        repeat (2) @(negedge clk);
        check("rst_dfp_read", bus.dfp_read, 1'b0);
        check("rst_dfp_write", bus.dfp_write, 1'b0);
        check("rst_dfp_addr", bus.dfp_addr, 32'h0);
        check("rst_dfp_wdata", bus.dfp_wdata, 256'h0);
        check("rst_i_resp", bus.i_resp, 1'b0);
        check("rst_d_resp", bus.d_resp, 1'b0);
        #2;
        rst    = 1'b0;
        mon_en = 1'b1;
        ad_en  = 1'b1;

        // Simultaneous requests from reset: I, D, I, D.
        fixed_lat = 1;
        grant_log.delete();
        fork
            begin
                i_txn(32'h0000_1000, 1'b0, n_i);
                i_txn(32'h0000_1020, 1'b0, n_i);
            end
            begin
                d_txn(32'h0000_2000, 1'b1, 1'b0, '0, 1'b0, 1'b0, n_d);
                d_txn(32'h0000_2020, 1'b1, 1'b0, '0, 1'b0, 1'b0, n_d);
            end
        join
        check("tie_grant_count", grant_log.size(), 4);
        check("tie_grant0", grant_log.size() > 0 ? grant_log[0] : 32'hFFFF_FFFF, 32'h0000_1000);
        check("tie_grant1", grant_log.size() > 1 ? grant_log[1] : 32'hFFFF_FFFF, 32'h0000_2000);
        check("tie_grant2", grant_log.size() > 2 ? grant_log[2] : 32'hFFFF_FFFF, 32'h0000_1020);
        check("tie_grant3", grant_log.size() > 3 ? grant_log[3] : 32'hFFFF_FFFF, 32'h0000_2020);

        // Instruction read, one-cycle request latency, aligned address.
        fixed_lat = 2;
        @(posedge clk);
        #1;
        bus.i_addr = 32'h0000_1234;
        bus.i_read = 1'b1;
        td.addr  = 32'h0000_1220;
        td.write = 1'b0;
        td.wdata = '0;
        td.cyc   = cyc;
        iq.push_back(td);
        @(negedge clk);
        check("i_lat0_read", bus.dfp_read, 1'b0);
        @(negedge clk);
        check("i_lat1_read", bus.dfp_read, 1'b1);
        check("i_lat1_addr", bus.dfp_addr, 32'h0000_1220);
        n_x = 1;
        while (n_x < TMO && !bus.i_resp) begin
            @(negedge clk);
            n_x++;
        end
        check("i_resp_a", bus.i_resp, 1'b1);
        check("i_rdata_a", bus.i_rdata, bus.dfp_rdata);
        check("d_resp_a", bus.d_resp, 1'b0);
        @(posedge clk);
        #1;
        bus.i_read = 1'b0;

        // Data writeback held through six wait cycles; inputs change after grant.
        fixed_lat = 6;
        pat_b = rand256();
        d_txn(32'h8000_0040, 1'b0, 1'b1, pat_b, 1'b0, 1'b1, n_d);
        check("d_write_latency", n_d, 8);

        // Read and write together: the write wins.
        fixed_lat = 0;
        d_txn(32'h0000_0abc, 1'b1, 1'b1, rand256(), 1'b0, 1'b0, n_d);

        // Request held one cycle past its response is not granted again.
        i_txn(32'h0000_0600, 1'b1, n_i);
        repeat (3) begin
            @(negedge clk);
            check("no_regrant", bus.dfp_read, 1'b0);
        end

        // Randomized traffic.
        fixed_lat = -1;
        fork
            begin
                for (int k = 0; k < 25; k++) begin
                    repeat ($urandom_range(0, 3)) @(posedge clk);
                    i_txn($urandom, 1'($urandom_range(0, 1)), n_i);
                end
            end
            begin
                for (int k = 0; k < 25; k++) begin
                    repeat ($urandom_range(0, 3)) @(posedge clk);
                    op = $urandom_range(0, 2);
                    d_txn($urandom, op != 1, op != 0, rand256(), 1'($urandom_range(0, 1)), 1'b0, n_d);
                end
            end
        join
        repeat (4) @(posedge clk);

        // Spurious adapter response in IDLE, with a new request in that cycle.
        fixed_lat = 1;
        @(posedge clk);
        #1;
        spur       = 1'b1;
        bus.i_addr = 32'h5555_5555;
        bus.i_read = 1'b1;
        td.addr  = 32'h5555_5540;
        td.write = 1'b0;
        td.wdata = '0;
        td.cyc   = cyc;
        iq.push_back(td);
        @(negedge clk);
        check("spur_i_resp", bus.i_resp, 1'b0);
        check("spur_d_resp", bus.d_resp, 1'b0);
        @(posedge clk);
        #1;
        spur = 1'b0;
        @(negedge clk);
        check("spur_still_idle", bus.dfp_read, 1'b1);
        n_x = 1;
        while (n_x < TMO && !bus.i_resp) begin
            @(negedge clk);
            n_x++;
        end
        check("spur_follow_resp", bus.i_resp, 1'b1);
        @(posedge clk);
        #1;
        bus.i_read = 1'b0;
        repeat (3) @(posedge clk);

        // Reset in the middle of a data writeback.
        mon_en = 1'b0;
        ad_en  = 1'b0;
        @(posedge clk);
        #1;
        bus.d_addr  = 32'h4000_0080;
        bus.d_write = 1'b1;
        bus.d_wdata = rand256();
        @(negedge clk);
        @(negedge clk);
        check("mid_pre_write", bus.dfp_write, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        check("mid_rst_write", bus.dfp_write, 1'b0);
        check("mid_rst_addr", bus.dfp_addr, 32'h0);
        check("mid_rst_wdata", bus.dfp_wdata, 256'h0);
        bus.d_write = 1'b0;
        @(negedge clk);
        check("mid_rst_held_write", bus.dfp_write, 1'b0);
        #2;
        rst = 1'b0;
        @(posedge clk);
        #1;
        spur = 1'b1;
        @(negedge clk);
        check("mid_late_d_resp", bus.d_resp, 1'b0);
        check("mid_late_i_resp", bus.i_resp, 1'b0);
        @(posedge clk);
        #1;
        spur = 1'b0;
        iq.delete();
        dq.delete();
        busy_m   = 1'b0;
        last_m   = 1'b1;
        idle_cnt = 2;
        mon_en   = 1'b1;
        ad_en    = 1'b1;

        // After reset the instruction cache wins the first tie again.
        fixed_lat = 0;
        grant_log.delete();
        fork
            i_txn(32'h0000_3000, 1'b0, n_i);
            d_txn(32'h0000_4000, 1'b1, 1'b0, '0, 1'b0, 1'b0, n_d);
        join
        check("post_rst_first_grant", grant_log.size() > 0 ? grant_log[0] : 32'hFFFF_FFFF, 32'h0000_3000);
        repeat (3) @(posedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        failures++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
